pipe_spawner: RTL and testbench

//   Producer of the pipe-position interface consumed by collision_det and the sprite renderer.

---
 rtl/pipe_spawner.sv | 138 +++++++++++++
 tb/tb_pipe_spawner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_spawner.sv
// Scrolls two pipes leftward one step per frame tick and respawns them on the right with an LFSR gap.
// Counts the pipes the bird clears, saturating at 999, with a one-cycle pulse for each pipe cleared.
module pipe_spawner #(
    parameter int          SCREEN_W     = 1024,
    parameter int          PIPE_W       = 80,
    parameter int          PIPE_SPACING = 512,
    parameter int          SPEED        = 4,
    parameter int          BIRD_X       = 200,
    parameter int          GAP_MIN      = 120,
    parameter int          GAP_RANGE    = 420,
    parameter int          GAP_INIT     = 334,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic        halt,
    input  logic        clear,
    output logic [11:0] pipe1_x,
    output logic [11:0] pipe1_gap_y,
    output logic [11:0] pipe2_x,
    output logic [11:0] pipe2_gap_y,
    output logic        running,
    output logic        score_pulse,
    output logic [9:0]  score,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FROZEN = 2'd2} state_t;

    localparam logic [11:0] C_SPEED   = 12'(SPEED);
    localparam logic [11:0] C_SPACING = 12'(PIPE_SPACING);
    localparam logic [11:0] C_P1_INIT = 12'(SCREEN_W);
    localparam logic [11:0] C_P2_INIT = 12'(SCREEN_W + PIPE_SPACING);
    localparam logic [11:0] C_GAP_MIN = 12'(GAP_MIN);
    localparam logic [11:0] C_GAP_IN  = 12'(GAP_INIT);
    localparam logic [8:0]  C_RANGE   = 9'(GAP_RANGE);
    localparam logic [9:0]  C_MAX_SC  = 10'd999;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_p1_x, r_p2_x, r_p1_gap, r_p2_gap;
    logic [9:0]  r_score;
    logic        r_pulse;
    logic [15:0] r_lfsr, w_lfsr_nxt;

    logic        w_move;
    logic [11:0] w_p1_mv, w_p2_mv, w_p1_nx, w_p2_nx;
    logic        w_p1_resp, w_p2_resp, w_p1_score, w_p2_score;
    logic [8:0]  w_v;
    logic [11:0] w_gap_new;

    // Scoring edge: trailing edge crosses the bird line; 13 bits so x+PIPE_W cannot wrap.
    function automatic logic crosses(input logic [11:0] x, input logic [11:0] nx);
        return (({1'b0, x} + 13'(PIPE_W)) >= 13'(BIRD_X)) &&
               (({1'b0, nx} + 13'(PIPE_W)) < 13'(BIRD_X));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Priority: clear over halt over start.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (start && !halt) w_state_nxt = S_RUN;
                S_RUN:    if (halt) w_state_nxt = S_FROZEN;
                S_FROZEN: w_state_nxt = S_FROZEN;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running   = (r_state == S_RUN);
        dbg_state = r_state;
    end

    assign w_move     = tick && (r_state == S_RUN) && !halt && !clear;
    assign w_p1_mv    = r_p1_x - C_SPEED;
    assign w_p2_mv    = r_p2_x - C_SPEED;
    assign w_p1_resp  = r_p1_x < C_SPEED;
    assign w_p2_resp  = r_p2_x < C_SPEED;
    assign w_p1_nx    = w_p1_resp ? (w_p2_mv + C_SPACING) : w_p1_mv;
    assign w_p2_nx    = w_p2_resp ? (w_p1_mv + C_SPACING) : w_p2_mv;
    assign w_p1_score = !w_p1_resp && crosses(r_p1_x, w_p1_mv);
    assign w_p2_score = !w_p2_resp && crosses(r_p2_x, w_p2_mv);

    assign w_v       = r_lfsr[8:0];
    assign w_gap_new = C_GAP_MIN + ((w_v >= C_RANGE) ? 12'(w_v - C_RANGE) : 12'(w_v));
    // Galois form of x^16+x^14+x^13+x^11+1; a zero state is forced back to the seed.
    assign w_lfsr_nxt = (r_lfsr == 16'h0000) ? LFSR_SEED :
                        ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr   <= LFSR_SEED;
            r_p1_x   <= C_P1_INIT;
            r_p2_x   <= C_P2_INIT;
            r_p1_gap <= C_GAP_IN;
            r_p2_gap <= C_GAP_IN;
            r_score  <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (clear) begin
                r_p1_x   <= C_P1_INIT;
                r_p2_x   <= C_P2_INIT;
                r_p1_gap <= C_GAP_IN;
                r_p2_gap <= C_GAP_IN;
                r_score  <= '0;
                r_pulse  <= 1'b0;
            end else begin
                r_pulse <= w_move && (w_p1_score || w_p2_score);
                if (w_move) begin
                    r_p1_x <= w_p1_nx;
                    r_p2_x <= w_p2_nx;
                    if (w_p1_resp) r_p1_gap <= w_gap_new;
                    if (w_p2_resp) r_p2_gap <= w_gap_new;
                    if ((w_p1_score || w_p2_score) && (r_score != C_MAX_SC))
                        r_score <= r_score + 10'd1;
                end
            end
        end
    end

    assign pipe1_x     = r_p1_x;
    assign pipe2_x     = r_p2_x;
    assign pipe1_gap_y = r_p1_gap;
    assign pipe2_gap_y = r_p2_gap;
    assign score       = r_score;
    assign score_pulse = r_pulse;

endmodule

// File: tb/tb_pipe_spawner.sv
// Bench for pipe_spawner: directed scenarios plus random stimulus against a behavioural model,
// and a fast-scrolling second instance used for gap-range and score-saturation runs.
module tb_pipe_spawner;
    localparam int          SPEED   = 4;
    localparam int          PW      = 80;
    localparam int          BX      = 200;
    localparam int          SPACING = 512;
    localparam int          GMIN    = 120;
    localparam int          GRANGE  = 420;
    localparam int          GINIT   = 334;
    localparam int          SW      = 1024;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick = 1'b0, start = 1'b0, halt = 1'b0, clear = 1'b0;
    logic [11:0] pipe1_x, pipe1_gap_y, pipe2_x, pipe2_gap_y;
    logic running, score_pulse;
    logic [9:0] score;
    logic [1:0] dbg_state;

    logic b_tick = 1'b0, b_start = 1'b0, b_halt = 1'b0, b_clear = 1'b0;
    logic [11:0] b_p1_x, b_g1, b_p2_x, b_g2;
    logic b_running, b_pulse;
    logic [9:0] b_score;
    logic [1:0] b_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int m_state, m_x1, m_x2, m_g1, m_g2, m_score;
    bit m_pulse;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    pipe_spawner u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .halt(halt), .clear(clear),
        .pipe1_x(pipe1_x), .pipe1_gap_y(pipe1_gap_y), .pipe2_x(pipe2_x), .pipe2_gap_y(pipe2_gap_y),
        .running(running), .score_pulse(score_pulse), .score(score), .dbg_state(dbg_state)
    );

    pipe_spawner #(.SCREEN_W(400), .PIPE_SPACING(200), .SPEED(15)) u_fast (
        .clk(clk), .rst_n(rst_n), .tick(b_tick), .start(b_start), .halt(b_halt), .clear(b_clear),
        .pipe1_x(b_p1_x), .pipe1_gap_y(b_g1), .pipe2_x(b_p2_x), .pipe2_gap_y(b_g2),
        .running(b_running), .score_pulse(b_pulse), .score(b_score), .dbg_state(b_dbg)
    );

    task automatic model_load();
        m_x1 = SW; m_x2 = SW + SPACING; m_g1 = GINIT; m_g2 = GINIT;
        m_score = 0; m_pulse = 0; m_state = M_IDLE;
    endtask

    task automatic model_step();
        logic [15:0] l;
        int n1, n2;
        bit r1, r2, s1, s2;
        l = m_lfsr;
        m_pulse = 0;
        if (clear) begin
            model_load();
        end else begin
            if (m_state == M_RUN && tick && !halt) begin
                r1 = m_x1 < SPEED;
                r2 = m_x2 < SPEED;
                n1 = r1 ? ((((m_x2 - SPEED) & 'hFFF) + SPACING) & 'hFFF) : m_x1 - SPEED;
                n2 = r2 ? ((((m_x1 - SPEED) & 'hFFF) + SPACING) & 'hFFF) : m_x2 - SPEED;
                s1 = !r1 && (m_x1 + PW >= BX) && (n1 + PW < BX);
                s2 = !r2 && (m_x2 + PW >= BX) && (n2 + PW < BX);
                if (r1) m_g1 = GMIN + (int'(l[8:0]) % GRANGE);
                if (r2) m_g2 = GMIN + (int'(l[8:0]) % GRANGE);
                if (s1 || s2) begin
                    m_pulse = 1;
                    if (m_score < 999) m_score++;
                end
                m_x1 = n1;
                m_x2 = n2;
            end
            if (m_state == M_IDLE && start && !halt) m_state = M_RUN;
            else if (m_state == M_RUN && halt) m_state = M_FROZEN;
        end
        if (l == 16'h0000) m_lfsr = SEED;
        else if (l[0]) m_lfsr = (l >> 1) ^ 16'hB400;
        else m_lfsr = l >> 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_load();
            m_lfsr = SEED;
        end else begin
            model_step();
        end
    end

    // Called just after a falling edge: inputs are seen at the next rising edge, results sampled at the following falling edge.
    task automatic step(input bit t, input bit s, input bit h, input bit c);
        tick = t; start = s; halt = h; clear = c;
        @(negedge clk);
        tick = 0; start = 0; halt = 0; clear = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        @(negedge clk);
        n_tests++; if (pipe1_x !== 12'd1024) begin n_fail++; $display("FAIL reset_p1x: got %0d expected 1024", pipe1_x); end
        n_tests++; if (pipe2_x !== 12'd1536) begin n_fail++; $display("FAIL reset_p2x: got %0d expected 1536", pipe2_x); end
        n_tests++; if (pipe1_gap_y !== 12'd334 || pipe2_gap_y !== 12'd334) begin n_fail++; $display("FAIL reset_gap: got %0d/%0d expected 334", pipe1_gap_y, pipe2_gap_y); end
        n_tests++; if (score !== 10'd0 || score_pulse !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL reset_flags: score %0d pulse %0b run %0b expected 0", score, score_pulse, running); end
        rst_n = 1;
    endtask

    task automatic test_idle_tick();
        step(1, 0, 0, 0);
        n_tests++; if (pipe1_x !== 12'd1024 || pipe2_x !== 12'd1536) begin n_fail++; $display("FAIL idle_tick: got %0d/%0d expected 1024/1536", pipe1_x, pipe2_x); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL idle_running: got %0b expected 0", running); end
    endtask

    task automatic test_start_move();
        step(0, 1, 0, 0);
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %0b expected 1", running); end
        step(1, 0, 0, 0);
        n_tests++; if (pipe1_x !== 12'd1020 || pipe2_x !== 12'd1532) begin n_fail++; $display("FAIL first_move: got %0d/%0d expected 1020/1532", pipe1_x, pipe2_x); end
    endtask

    task automatic test_score();
        int k = 0;
        while (pipe1_x !== 12'd120 && k < 400) begin step(1, 0, 0, 0); k++; end
        n_tests++; if (pipe1_x !== 12'd120 || score_pulse !== 1'b0 || score !== 10'd0) begin n_fail++; $display("FAIL approach: x %0d pulse %0b score %0d expected 120/0/0", pipe1_x, score_pulse, score); end
        step(1, 0, 0, 0);
        n_tests++; if (pipe1_x !== 12'd116 || pipe2_x !== 12'd628) begin n_fail++; $display("FAIL score_move: got %0d/%0d expected 116/628", pipe1_x, pipe2_x); end
        n_tests++; if (score_pulse !== 1'b1 || score !== 10'd1) begin n_fail++; $display("FAIL score_pulse: pulse %0b score %0d expected 1/1", score_pulse, score); end
        step(0, 0, 0, 0);
        n_tests++; if (score_pulse !== 1'b0 || score !== 10'd1) begin n_fail++; $display("FAIL pulse_width: pulse %0b score %0d expected 0/1", score_pulse, score); end
    endtask

    task automatic test_respawn();
        int k = 0;
        while (pipe1_x !== 12'd0 && k < 100) begin step(1, 0, 0, 0); k++; end
        n_tests++; if (pipe1_x !== 12'd0 || pipe2_x !== 12'd512) begin n_fail++; $display("FAIL pre_respawn: got %0d/%0d expected 0/512", pipe1_x, pipe2_x); end
        step(1, 0, 0, 0);
        n_tests++; if (pipe1_x !== 12'd1020 || pipe2_x !== 12'd508) begin n_fail++; $display("FAIL respawn_x: got %0d/%0d expected 1020/508", pipe1_x, pipe2_x); end
        n_tests++; if (pipe1_gap_y < 12'd120 || pipe1_gap_y > 12'd539) begin n_fail++; $display("FAIL respawn_gap_range: got %0d expected 120..539", pipe1_gap_y); end
        n_tests++; if (pipe1_gap_y !== 12'(m_g1)) begin n_fail++; $display("FAIL respawn_gap_value: got %0d expected %0d", pipe1_gap_y, m_g1); end
        n_tests++; if (score_pulse !== 1'b0 || score !== 10'd1) begin n_fail++; $display("FAIL respawn_noscore: pulse %0b score %0d expected 0/1", score_pulse, score); end
    endtask

    task automatic test_halt_clear();
        step(1, 0, 1, 0);
        n_tests++; if (pipe1_x !== 12'd1020 || pipe2_x !== 12'd508 || running !== 1'b0) begin n_fail++; $display("FAIL halt_tick: got %0d/%0d run %0b expected 1020/508/0", pipe1_x, pipe2_x, running); end
        repeat (5) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_tests++; if (pipe1_x !== 12'd1020 || pipe2_x !== 12'd508 || running !== 1'b0 || score !== 10'd1) begin n_fail++; $display("FAIL frozen_hold: got %0d/%0d run %0b score %0d expected 1020/508/0/1", pipe1_x, pipe2_x, running, score); end
        step(1, 0, 0, 1);
        n_tests++; if (pipe1_x !== 12'd1024 || pipe2_x !== 12'd1536 || pipe1_gap_y !== 12'd334 || pipe2_gap_y !== 12'd334) begin n_fail++; $display("FAIL clear_pos: got %0d/%0d gaps %0d/%0d expected 1024/1536/334/334", pipe1_x, pipe2_x, pipe1_gap_y, pipe2_gap_y); end
        n_tests++; if (score !== 10'd0 || running !== 1'b0) begin n_fail++; $display("FAIL clear_state: score %0d run %0b expected 0/0", score, running); end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0);
        repeat (10) step(1, 0, 0, 0);
        n_tests++; if (pipe1_x !== 12'd984) begin n_fail++; $display("FAIL pre_async: got %0d expected 984", pipe1_x); end
        #2 rst_n = 0;
        #1;
        n_tests++; if (pipe1_x !== 12'd1024 || pipe2_x !== 12'd1536 || running !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %0d/%0d run %0b expected 1024/1536/0", pipe1_x, pipe2_x, running); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        bit t, s, h, c;
        for (int i = 0; i < 4000; i++) begin
            t = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 399) == 0);
            h = ($urandom_range(0, 599) == 0);
            s = !h && ($urandom_range(0, 9) == 0);
            step(t, s, h, c);
            n_tests++; if (pipe1_x !== 12'(m_x1)) begin n_fail++; $display("FAIL rnd_p1x cyc %0d: got %0d expected %0d", i, pipe1_x, m_x1); end
            n_tests++; if (pipe2_x !== 12'(m_x2)) begin n_fail++; $display("FAIL rnd_p2x cyc %0d: got %0d expected %0d", i, pipe2_x, m_x2); end
            n_tests++; if (pipe1_gap_y !== 12'(m_g1)) begin n_fail++; $display("FAIL rnd_g1 cyc %0d: got %0d expected %0d", i, pipe1_gap_y, m_g1); end
            n_tests++; if (pipe2_gap_y !== 12'(m_g2)) begin n_fail++; $display("FAIL rnd_g2 cyc %0d: got %0d expected %0d", i, pipe2_gap_y, m_g2); end
            n_tests++; if (score !== 10'(m_score)) begin n_fail++; $display("FAIL rnd_score cyc %0d: got %0d expected %0d", i, score, m_score); end
            n_tests++; if (score_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse cyc %0d: got %0b expected %0b", i, score_pulse, m_pulse); end
            n_tests++; if (running !== (m_state == M_RUN)) begin n_fail++; $display("FAIL rnd_running cyc %0d: got %0b expected %0b", i, running, (m_state == M_RUN)); end
        end
    endtask

    task automatic test_saturate();
        int resp = 0, pulses = 0, k = 0, exp_sc;
        logic [11:0] prev1, prev2;
        b_clear = 1; @(negedge clk); b_clear = 0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        b_start = 1; @(negedge clk); b_start = 0;
        n_tests++; if (b_running !== 1'b1 || b_score !== 10'd0) begin n_fail++; $display("FAIL fast_start: run %0b score %0d expected 1/0", b_running, b_score); end
        prev1 = b_p1_x; prev2 = b_p2_x;
        while ((resp < 1000 || pulses < 1010) && k < 60000) begin
            b_tick = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k++;
            if (b_p1_x > prev1) begin
                resp++;
                n_tests++; if (b_g1 < 12'd120 || b_g1 > 12'd539) begin n_fail++; $display("FAIL fast_gap1: got %0d expected 120..539", b_g1); end
            end
            if (b_p2_x > prev2) begin
                resp++;
                n_tests++; if (b_g2 < 12'd120 || b_g2 > 12'd539) begin n_fail++; $display("FAIL fast_gap2: got %0d expected 120..539", b_g2); end
            end
            if (b_pulse) begin
                pulses++;
                exp_sc = (pulses > 999) ? 999 : pulses;
                n_tests++; if (b_score !== 10'(exp_sc)) begin n_fail++; $display("FAIL fast_score: got %0d expected %0d", b_score, exp_sc); end
            end
            prev1 = b_p1_x; prev2 = b_p2_x;
        end
        b_tick = 0;
        n_tests++; if (k >= 60000) begin n_fail++; $display("FAIL fast_timeout: respawns %0d pulses %0d expected 1000/1010", resp, pulses); end
        n_tests++; if (b_score !== 10'd999) begin n_fail++; $display("FAIL fast_saturate: got %0d expected 999", b_score); end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_start_move();
        test_score();
        test_respawn();
        test_halt_clear();
        test_async_reset();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
